// File: rtl/lldma_system.sv
// lldma_system: DCR-programmed bus slave engine plus a small memory-backed
// bus master responder, with tx/rx level interrupts.
// Every bus is numbered big-endian, so bit 0 is the MSB.
module lldma_system #(
    parameter int         MEM_AW   = 10,
    parameter logic [0:5] DCR_BASE = 6'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        Bus2IP_Clk,
    output logic        Bus2IP_Reset,
    output logic [0:31] Bus2IP_Addr,
    output logic [0:31] Bus2IP_Data,
    output logic [0:3]  Bus2IP_BE,
    output logic        Bus2IP_RNW,
    output logic        Bus2IP_CS,
    output logic        Bus2IP_WrReq,
    output logic        Bus2IP_RdReq,
    output logic        Bus2IP_RdCE,
    output logic        Bus2IP_WrCE,
    output logic        Bus2IP_Burst,
    output logic [0:7]  Bus2IP_BurstLength,
    input  logic [0:31] IP2Bus_Data,
    input  logic        IP2Bus_WrAck,
    input  logic        IP2Bus_RdAck,
    input  logic        IP2Bus_AddrAck,
    input  logic        IP2Bus_Error,
    input  logic        IP2Bus_MstRd_Req,
    input  logic        IP2Bus_MstWr_Req,
    input  logic        IP2Bus_Mst_Lock,
    input  logic        IP2Bus_Mst_Reset,
    input  logic [0:31] IP2Bus_Mst_Addr,
    input  logic [0:3]  IP2Bus_Mst_BE,
    input  logic [0:31] IP2Bus_MstWr_d,
    output logic        Bus2IP_Mst_CmdAck,
    output logic        Bus2IP_Mst_Cmplt,
    output logic        Bus2IP_Mst_Error,
    output logic        Bus2IP_Mst_Rearbitrate,
    output logic        Bus2IP_Mst_Cmd_Timeout,
    output logic        Bus2IP_MstRd_src_rdy_n,
    output logic        Bus2IP_MstWr_dst_rdy_n,
    output logic [0:31] Bus2IP_MstRd_d,
    input  logic        DCR_Read,
    input  logic        DCR_Write,
    input  logic [0:9]  DCR_ABus,
    input  logic [0:31] DCR_Sl_DBus,
    output logic        Sl_dcrAck,
    output logic        Sl_dcrTimeoutWait,
    output logic [0:31] Sl_dcrDBus,
    output logic        tx_interrupt,
    output logic        rx_interrupt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} s_state_t;
    typedef enum logic [1:0] {M_IDLE, M_ACK, M_DATA, M_CMPLT} m_state_t;

    localparam logic [0:31] ID_VALUE = 32'h4C4C444D;

    s_state_t    s_state_q, s_state_d;
    m_state_t    m_state_q, m_state_d;
    logic [5:0]  s_cnt_q, s_cnt_d;
    logic        s_rnw_q, s_rnw_d;
    logic [0:3]  s_be_q, s_be_d;
    logic [0:31] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, s_rdata_q, s_rdata_d;
    logic        tx_done_q, tx_done_d, rx_done_q, rx_done_d, slv_err_q, slv_err_d;
    logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [0:31] m_addr_q, m_addr_d;
    logic [0:3]  m_be_q, m_be_d;
    logic        m_rnw_q, m_rnw_d;
    logic        dcr_ack_q, dcr_ack_d, dcr_done_q, dcr_done_d;
    logic [0:31] dcr_rdata_q, dcr_rdata_d;
    logic        rst_out_q;

    logic [0:31]       mem [0:(1<<MEM_AW)-1];
    logic [0:31]       mem_rd_q;
    logic [MEM_AW-1:0] m_word;
    logic              m_err, mem_we, m_rd_valid;
    logic              s_busy, s_start, s_ack, s_timeout;
    logic              dcr_hit, dcr_fire, dcr_wr;
    logic [3:0]        dcr_off;
    logic [0:31]       rd_word;
    logic              unused_ok;

    assign m_word    = m_addr_q[30-MEM_AW:29];
    assign m_err     = ({1'b0, m_addr_q} >= (33'd1 << (MEM_AW + 2)));
    assign mem_we    = (m_state_q == M_DATA) && !m_rnw_q && !m_err && !IP2Bus_Mst_Reset;
    assign m_rd_valid = (m_state_q == M_DATA) && m_rnw_q && !m_err && !IP2Bus_Mst_Reset;
    assign s_busy    = (s_state_q != S_IDLE);
    assign unused_ok = &{1'b0, IP2Bus_AddrAck, IP2Bus_Mst_Lock};

    // Next-state logic: DCR register file, slave engine and master engine
    always_comb begin
        s_state_d   = s_state_q;
        m_state_d   = m_state_q;
        s_cnt_d     = s_cnt_q;
        s_rnw_d     = s_rnw_q;
        s_be_d      = s_be_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_rdata_d   = s_rdata_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        slv_err_d   = slv_err_q;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        m_addr_d    = m_addr_q;
        m_be_d      = m_be_q;
        m_rnw_d     = m_rnw_q;
        s_start     = 1'b0;
        rd_word     = '0;

        // DCR handshake: one ack per request, re-armed when the request drops
        dcr_off     = DCR_ABus[6:9];
        dcr_hit     = (DCR_ABus[0:5] == DCR_BASE) && (DCR_Read || DCR_Write);
        dcr_fire    = dcr_hit && !dcr_ack_q && !dcr_done_q;
        dcr_wr      = dcr_fire && DCR_Write;
        dcr_ack_d   = dcr_fire;
        dcr_done_d  = dcr_hit && (dcr_done_q || dcr_ack_q);

        case (dcr_off)
            4'd0: begin
                rd_word[30]    = s_rnw_q;
                rd_word[24:27] = s_be_q;
            end
            4'd1: rd_word = s_addr_q;
            4'd2: rd_word = s_wdata_q;
            4'd3: rd_word = s_rdata_q;
            4'd4: rd_word[28:31] = {s_busy, slv_err_q, rx_done_q, tx_done_q};
            4'd5: rd_word[30:31] = {rx_en_q, tx_en_q};
            4'd6: rd_word = ID_VALUE;
            default: rd_word = '0;
        endcase
        dcr_rdata_d = (dcr_fire && DCR_Read) ? rd_word : '0;

        // Register writes; status clears come first so hardware sets below win
        if (dcr_wr) begin
            case (dcr_off)
                4'd0: if (!s_busy) begin
                    s_rnw_d = DCR_Sl_DBus[30];
                    s_be_d  = DCR_Sl_DBus[24:27];
                    s_start = DCR_Sl_DBus[31];
                end
                4'd1: s_addr_d  = DCR_Sl_DBus;
                4'd2: s_wdata_d = DCR_Sl_DBus;
                4'd4: begin
                    if (DCR_Sl_DBus[31]) tx_done_d = 1'b0;
                    if (DCR_Sl_DBus[30]) rx_done_d = 1'b0;
                    if (DCR_Sl_DBus[29]) slv_err_d = 1'b0;
                end
                4'd5: begin
                    tx_en_d = DCR_Sl_DBus[31];
                    rx_en_d = DCR_Sl_DBus[30];
                end
                default: ;
            endcase
        end

        // Slave engine: request for one cycle, then wait for ack/error/timeout
        s_ack     = s_rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;
        s_timeout = (s_cnt_q == 6'd63);
        case (s_state_q)
            S_IDLE: if (s_start) begin
                s_state_d = S_REQ;
                s_cnt_d   = '0;
            end
            S_REQ: s_state_d = S_WAIT;
            S_WAIT: begin
                if (s_ack || IP2Bus_Error || s_timeout) begin
                    s_state_d = S_IDLE;
                    s_cnt_d   = '0;
                    tx_done_d = 1'b1;
                    if (IP2Bus_Error || !s_ack) slv_err_d = 1'b1;
                    if (s_ack && s_rnw_q) s_rdata_d = IP2Bus_Data;
                end else begin
                    s_cnt_d = s_cnt_q + 6'd1;
                end
            end
            default: s_state_d = S_IDLE;
        endcase

        // Master engine: fixed ack/data/complete sequence, abortable at any point
        case (m_state_q)
            M_IDLE: if (IP2Bus_MstRd_Req || IP2Bus_MstWr_Req) begin
                m_state_d = M_ACK;
                m_addr_d  = IP2Bus_Mst_Addr;
                m_be_d    = IP2Bus_Mst_BE;
                m_rnw_d   = IP2Bus_MstRd_Req;
            end
            M_ACK:   m_state_d = M_DATA;
            M_DATA:  m_state_d = M_CMPLT;
            M_CMPLT: begin
                m_state_d = M_IDLE;
                if (!m_rnw_q && !m_err && !IP2Bus_Mst_Reset) rx_done_d = 1'b1;
            end
            default: m_state_d = M_IDLE;
        endcase
        if (IP2Bus_Mst_Reset) m_state_d = M_IDLE;
    end

    // State and register update with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        rst_out_q <= ~sys_rst;
        if (!sys_rst) begin
            s_state_q   <= S_IDLE;
            m_state_q   <= M_IDLE;
            s_cnt_q     <= '0;
            s_rnw_q     <= 1'b0;
            s_be_q      <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_rdata_q   <= '0;
            tx_done_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            slv_err_q   <= 1'b0;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            m_addr_q    <= '0;
            m_be_q      <= '0;
            m_rnw_q     <= 1'b0;
            dcr_ack_q   <= 1'b0;
            dcr_done_q  <= 1'b0;
            dcr_rdata_q <= '0;
        end else begin
            s_state_q   <= s_state_d;
            m_state_q   <= m_state_d;
            s_cnt_q     <= s_cnt_d;
            s_rnw_q     <= s_rnw_d;
            s_be_q      <= s_be_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_rdata_q   <= s_rdata_d;
            tx_done_q   <= tx_done_d;
            rx_done_q   <= rx_done_d;
            slv_err_q   <= slv_err_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            m_addr_q    <= m_addr_d;
            m_be_q      <= m_be_d;
            m_rnw_q     <= m_rnw_d;
            dcr_ack_q   <= dcr_ack_d;
            dcr_done_q  <= dcr_done_d;
            dcr_rdata_q <= dcr_rdata_d;
        end
    end

    // Master memory: byte-masked write, registered read ready by the data phase
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_be_q[b]) mem[m_word][8*b +: 8] <= IP2Bus_MstWr_d[8*b +: 8];
            end
        end
        mem_rd_q <= mem[m_word];
    end

    assign Bus2IP_Clk             = sys_clk;
    assign Bus2IP_Reset           = rst_out_q;
    assign Bus2IP_CS              = s_busy;
    assign Bus2IP_RNW             = s_busy && s_rnw_q;
    assign Bus2IP_RdCE            = s_busy && s_rnw_q;
    assign Bus2IP_WrCE            = s_busy && !s_rnw_q;
    assign Bus2IP_RdReq           = (s_state_q == S_REQ) && s_rnw_q;
    assign Bus2IP_WrReq           = (s_state_q == S_REQ) && !s_rnw_q;
    assign Bus2IP_Addr            = s_busy ? s_addr_q : '0;
    assign Bus2IP_Data            = s_busy ? s_wdata_q : '0;
    assign Bus2IP_BE              = s_busy ? s_be_q : '0;
    assign Bus2IP_Burst           = 1'b0;
    assign Bus2IP_BurstLength     = '0;
    assign Bus2IP_Mst_CmdAck      = (m_state_q == M_ACK);
    assign Bus2IP_Mst_Cmplt       = (m_state_q == M_CMPLT) && !IP2Bus_Mst_Reset;
    assign Bus2IP_Mst_Error       = Bus2IP_Mst_Cmplt && m_err;
    assign Bus2IP_Mst_Rearbitrate = 1'b0;
    assign Bus2IP_Mst_Cmd_Timeout = 1'b0;
    assign Bus2IP_MstRd_src_rdy_n = !m_rd_valid;
    assign Bus2IP_MstWr_dst_rdy_n = !mem_we;
    assign Bus2IP_MstRd_d         = m_rd_valid ? mem_rd_q : '0;
    assign Sl_dcrAck              = dcr_ack_q;
    assign Sl_dcrDBus             = dcr_rdata_q;
    assign Sl_dcrTimeoutWait      = 1'b0;
    assign tx_interrupt           = tx_done_q && tx_en_q;
    assign rx_interrupt           = rx_done_q && rx_en_q;

endmodule

// File: tb/tb_lldma_system.sv
// Directed testbench for lldma_system: DCR registers, master port, slave engine.
module tb_lldma_system;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        Bus2IP_Clk, Bus2IP_Reset;
    logic [0:31] Bus2IP_Addr, Bus2IP_Data;
    logic [0:3]  Bus2IP_BE;
    logic        Bus2IP_RNW, Bus2IP_CS, Bus2IP_WrReq, Bus2IP_RdReq, Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Burst;
    logic [0:7]  Bus2IP_BurstLength;
    logic [0:31] IP2Bus_Data = '0;
    logic        IP2Bus_WrAck = 0, IP2Bus_RdAck = 0, IP2Bus_AddrAck = 0, IP2Bus_Error = 0;
    logic        IP2Bus_MstRd_Req = 0, IP2Bus_MstWr_Req = 0, IP2Bus_Mst_Lock = 0, IP2Bus_Mst_Reset = 0;
    logic [0:31] IP2Bus_Mst_Addr = '0;
    logic [0:3]  IP2Bus_Mst_BE = '0;
    logic [0:31] IP2Bus_MstWr_d = '0;
    logic        Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Rearbitrate;
    logic        Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n;
    logic [0:31] Bus2IP_MstRd_d;
    logic        DCR_Read = 0, DCR_Write = 0;
    logic [0:9]  DCR_ABus = '0;
    logic [0:31] DCR_Sl_DBus = '0;
    logic        Sl_dcrAck, Sl_dcrTimeoutWait;
    logic [0:31] Sl_dcrDBus;
    logic        tx_interrupt, rx_interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    // slave-side monitor state
    int          cs_cycles = 0, rdreq_cnt = 0, wrreq_cnt = 0;
    logic [31:0] cap_addr = '0, cap_data = '0, cap_be = '0;
    bit          ip_ack_en = 0;

    lldma_system #(.MEM_AW(10), .DCR_BASE(6'h00)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Reset(Bus2IP_Reset),
        .Bus2IP_Addr(Bus2IP_Addr), .Bus2IP_Data(Bus2IP_Data), .Bus2IP_BE(Bus2IP_BE),
        .Bus2IP_RNW(Bus2IP_RNW), .Bus2IP_CS(Bus2IP_CS), .Bus2IP_WrReq(Bus2IP_WrReq),
        .Bus2IP_RdReq(Bus2IP_RdReq), .Bus2IP_RdCE(Bus2IP_RdCE), .Bus2IP_WrCE(Bus2IP_WrCE),
        .Bus2IP_Burst(Bus2IP_Burst), .Bus2IP_BurstLength(Bus2IP_BurstLength),
        .IP2Bus_Data(IP2Bus_Data), .IP2Bus_WrAck(IP2Bus_WrAck), .IP2Bus_RdAck(IP2Bus_RdAck),
        .IP2Bus_AddrAck(IP2Bus_AddrAck), .IP2Bus_Error(IP2Bus_Error),
        .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock), .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
        .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
        .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
        .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
        .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout),
        .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
        .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
        .DCR_Read(DCR_Read), .DCR_Write(DCR_Write), .DCR_ABus(DCR_ABus), .DCR_Sl_DBus(DCR_Sl_DBus),
        .Sl_dcrAck(Sl_dcrAck), .Sl_dcrTimeoutWait(Sl_dcrTimeoutWait), .Sl_dcrDBus(Sl_dcrDBus),
        .tx_interrupt(tx_interrupt), .rx_interrupt(rx_interrupt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One DCR access held for four cycles; returns ack count and read data
    task automatic dcr_access(input bit wr, input logic [5:0] base, input logic [3:0] off,
                              input logic [31:0] wdata, output logic [31:0] rdata, output int acks);
        acks  = 0;
        rdata = '0;
        @(posedge sys_clk); #1;
        DCR_ABus    = {base, off};
        DCR_Sl_DBus = wdata;
        DCR_Write   = wr;
        DCR_Read    = !wr;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            if (Sl_dcrAck) begin
                acks++;
                rdata = Sl_dcrDBus;
            end
        end
        DCR_Write = 0;
        DCR_Read  = 0;
        @(posedge sys_clk); #1;
    endtask

    task automatic dcr_wr(input logic [3:0] off, input logic [31:0] wdata);
        logic [31:0] rd;
        int acks;
        dcr_access(1'b1, 6'h00, off, wdata, rd, acks);
        check($sformatf("dcr_wr_ack_off%0d", off), acks, 1);
    endtask

    task automatic dcr_rd_check(input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int acks;
        dcr_access(1'b0, 6'h00, off, 32'h0, rd, acks);
        check($sformatf("dcr_rd_ack_off%0d", off), acks, 1);
        check($sformatf("dcr_rd_data_off%0d", off), rd, exp);
    endtask

    // Master transfer: observe ack/data/complete phases over a bounded window
    task automatic mst_xfer(input string tag, input bit rnw, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata, input bit abort,
                            input bit exp_err, input logic [31:0] exp_rd);
        int ack_n = 0, rdy_n = 0, cmplt_n = 0, cmplt_cyc = 0;
        logic err_seen = 0;
        logic [31:0] rd = '0;
        @(posedge sys_clk); #1;
        IP2Bus_Mst_Addr  = addr;
        IP2Bus_Mst_BE    = be;
        IP2Bus_MstWr_d   = wdata;
        IP2Bus_MstRd_Req = rnw;
        IP2Bus_MstWr_Req = !rnw;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge sys_clk); #1;
            if (!Bus2IP_MstRd_src_rdy_n) begin rdy_n++; rd = Bus2IP_MstRd_d; end
            if (!Bus2IP_MstWr_dst_rdy_n) rdy_n++;
            if (Bus2IP_Mst_Cmplt) begin cmplt_n++; cmplt_cyc = cyc; err_seen = Bus2IP_Mst_Error; end
            if (IP2Bus_Mst_Reset) IP2Bus_Mst_Reset = 0;
            if (Bus2IP_Mst_CmdAck) begin
                ack_n++;
                IP2Bus_MstRd_Req = 0;
                IP2Bus_MstWr_Req = 0;
                if (abort) IP2Bus_Mst_Reset = 1;
            end
        end
        IP2Bus_MstRd_Req = 0;
        IP2Bus_MstWr_Req = 0;
        check({tag, "_cmdack"}, ack_n, 1);
        if (abort) begin
            check({tag, "_cmplt_none"}, cmplt_n, 0);
            check({tag, "_rdy_none"}, rdy_n, 0);
        end else begin
            check({tag, "_cmplt"}, cmplt_n, 1);
            check({tag, "_cmplt_cyc"}, cmplt_cyc, 3);
            check({tag, "_err"}, {31'b0, err_seen}, {31'b0, exp_err});
            check({tag, "_rdy"}, rdy_n, exp_err ? 0 : 1);
            if (rnw && !exp_err) check({tag, "_rdata"}, rd, exp_rd);
        end
    endtask

    // Slave port monitor
    always @(negedge sys_clk) begin
        if (Bus2IP_CS) cs_cycles++;
        if (Bus2IP_RdReq) begin
            rdreq_cnt++;
            cap_addr = Bus2IP_Addr;
            cap_be   = {28'b0, Bus2IP_BE};
        end
        if (Bus2IP_WrReq) begin
            wrreq_cnt++;
            cap_data = Bus2IP_Data;
        end
    end

    // IP model: answers a read request with RdAck three cycles later
    initial begin
        forever begin
            @(negedge sys_clk);
            if (Bus2IP_RdReq && ip_ack_en) begin
                repeat (3) @(posedge sys_clk);
                #1;
                IP2Bus_RdAck = 1;
                IP2Bus_Data  = 32'h12345678;
                @(posedge sys_clk); #1;
                IP2Bus_RdAck = 0;
                IP2Bus_Data  = '0;
            end
        end
    end

    task automatic wait_slave_idle(input string tag);
        for (int i = 0; i < 200 && Bus2IP_CS; i++) begin
            @(posedge sys_clk); #1;
        end
        check({tag, "_idle"}, {31'b0, Bus2IP_CS}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int acks;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_bus2ip_reset", {31'b0, Bus2IP_Reset}, 32'h1);
        check("rst_src_rdy_n", {31'b0, Bus2IP_MstRd_src_rdy_n}, 32'h1);
        check("rst_dst_rdy_n", {31'b0, Bus2IP_MstWr_dst_rdy_n}, 32'h1);
        check("rst_outputs", {26'b0, Bus2IP_CS, Sl_dcrAck, Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt,
                              tx_interrupt, rx_interrupt}, 32'h0);
        check("rst_dcr_dbus", Sl_dcrDBus, 32'h0);
        sys_rst = 1;
        @(posedge sys_clk); #1;
        check("run_bus2ip_reset", {31'b0, Bus2IP_Reset}, 32'h0);

        // DCR register file
        dcr_wr(4'd5, 32'h3);
        dcr_rd_check(4'd6, 32'h4C4C444D);
        dcr_rd_check(4'd5, 32'h3);
        dcr_rd_check(4'd4, 32'h0);
        dcr_rd_check(4'd7, 32'h0);
        dcr_access(1'b0, 6'h01, 4'd6, 32'h0, rd, acks);
        check("dcr_bad_base_ack", acks, 0);

        // Master port: write then read back, byte masking, last word
        mst_xfer("mwr10", 1'b0, 32'h10, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        check("rx_int_after_wr", {31'b0, rx_interrupt}, 32'h1);
        mst_xfer("mrd10", 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);
        mst_xfer("mwr14a", 1'b0, 32'h14, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0);
        mst_xfer("mwr14b", 1'b0, 32'h14, 4'b1010, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0);
        mst_xfer("mrd14", 1'b1, 32'h14, 4'hF, 32'h0, 1'b0, 1'b0, 32'hAA22CC44);
        mst_xfer("mwrffc", 1'b0, 32'hFFC, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        mst_xfer("mrdffc", 1'b1, 32'hFFC, 4'hF, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D);
        dcr_wr(4'd4, 32'h2);
        check("rx_int_cleared", {31'b0, rx_interrupt}, 32'h0);

        // Out-of-range and aborted transfers
        mst_xfer("mrd_oor", 1'b1, 32'h1000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0);
        mst_xfer("mwr_oor", 1'b0, 32'h1000, 4'hF, 32'h55555555, 1'b0, 1'b1, 32'h0);
        mst_xfer("mrd_abort", 1'b1, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
        dcr_rd_check(4'd4, 32'h0);

        // Slave read answered by the IP
        ip_ack_en = 1;
        rdreq_cnt = 0;
        wrreq_cnt = 0;
        dcr_wr(4'd1, 32'h40);
        dcr_wr(4'd0, 32'h000000F3);
        wait_slave_idle("srd");
        check("srd_rdreq_cnt", rdreq_cnt, 1);
        check("srd_wrreq_cnt", wrreq_cnt, 0);
        check("srd_addr", cap_addr, 32'h40);
        check("srd_be", cap_be, 32'hF);
        dcr_rd_check(4'd3, 32'h12345678);
        check("tx_int_set", {31'b0, tx_interrupt}, 32'h1);
        dcr_rd_check(4'd4, 32'h1);
        dcr_wr(4'd4, 32'h1);
        check("tx_int_cleared", {31'b0, tx_interrupt}, 32'h0);

        // Slave write with no answer: timeout; GO while busy is ignored
        ip_ack_en = 0;
        dcr_wr(4'd2, 32'hDEADBEEF);
        cs_cycles = 0;
        wrreq_cnt = 0;
        dcr_wr(4'd0, 32'h000000F1);
        dcr_rd_check(4'd4, 32'h8);
        dcr_wr(4'd0, 32'h000000F1);
        wait_slave_idle("swr");
        check("swr_wrreq_cnt", wrreq_cnt, 1);
        check("swr_data", cap_data, 32'hDEADBEEF);
        check("swr_cs_cycles", cs_cycles, 65);
        dcr_rd_check(4'd4, 32'h5);
        check("tx_int_timeout", {31'b0, tx_interrupt}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
